m68k_reg_target: RTL
====================

// Module: m68k_reg_target
// PURPOSE
//  68000 bus responder: answers host-68k (or PiStorm-initiated) bus cycles that hit a small
//  word register window, asserting DTACK_n with optional wait states. Local side gives the
//  CPLD logic read/write access plus a doorbell IRQ. Responder counterpart of the bus master.
// PARAMETERS
//  BASE_ADDR    24'hE90000  byte base of window; compared on A[23:ADDR_BITS+1]
//  ADDR_BITS    3           log2 of word register count (8 x 16-bit)
//  WAIT_STATES  0           extra M68K_CLK cycles between decode and DTACK (0..15)
// PORTS
//  M68K_CLK      in   1   7 MHz bus clock; all logic on rising edge
//  M68K_RESET_n  in   1   synchronous, active-low reset
//  M68K_A        in   23  address A[23:1]
//  M68K_AS_n     in   1   address strobe
//  M68K_UDS_n    in   1   upper data strobe (D[15:8])
//  M68K_LDS_n    in   1   lower data strobe (D[7:0])
//  M68K_RW       in   1   1=read, 0=write
//  M68K_D_IN     in   16  data bus input
//  M68K_D_OUT    out  16  read data to drive
//  M68K_D_OE     out  1   drive M68K_D_OUT onto bus
//  M68K_DTACK_n  out  1   DTACK level when M68K_DTACK_OE=1
//  M68K_DTACK_OE out  1   drive DTACK (else tri-state at top level)
//  LOC_ADDR      in   ADDR_BITS  local register index
//  LOC_RDATA     out  16  register[LOC_ADDR], combinational
//  LOC_WE        in   1   local write strobe
//  LOC_WDATA     in   16  local write data (full word)
//  LOC_IRQ       out  1   doorbell: set by bus write to index 0
//  LOC_IRQ_ACK   in   1   clears LOC_IRQ
//  LOC_COLLIDE   out  1   1-cycle pulse: local write dropped by same-index bus write
// BEHAVIOUR
//  Reset (M68K_RESET_n=0 at posedge): regs=0, state=IDLE, armed=0, D_OE=0, DTACK_OE=0,
//   DTACK_n=1, D_OUT=0, LOC_IRQ=0, LOC_COLLIDE=0. Reset mid-cycle aborts instantly.
//  armed: set when AS_n sampled 1; cleared by reset. IDLE ignores AS_n=0 while !armed
//   (no response to a cycle already in progress at reset release).
//  hit = !AS_n & armed & A[23:ADDR_BITS+1]==BASE_ADDR[23:ADDR_BITS+1]; idx=A[ADDR_BITS:1].
//  FSM (per posedge):
//   IDLE: hit -> latch idx,RW; WAIT_STATES==0 ? ACK : WAIT (cnt=WAIT_STATES-1). Miss: stay.
//   WAIT: AS_n=1 -> IDLE (aborted, no write). cnt==0 -> ACK else cnt--.
//   ACK entry cycle: DTACK_OE=1, DTACK_n=0. Read: D_OUT=reg[idx], D_OE=1.
//    Write: commit D_IN byte lanes per sampled !UDS_n/!LDS_n, once, at ACK entry.
//    Stay in ACK until AS_n sampled 1 -> REL.
//   REL: DTACK_n=1, DTACK_OE=1, D_OE=0 for one cycle -> IDLE (DTACK_OE=0).
//  Latency (WAIT_STATES=0): DTACK_n low 1 cycle after first posedge with hit; release
//   within 1 cycle of AS_n negation; min cycle IDLE->ACK->REL->IDLE = 3 clocks.
//  Write with both DS negated: no register change, still acknowledged.
//  Local write: reg[LOC_ADDR]<=LOC_WDATA. Same cycle as bus commit to same index: bus wins,
//   LOC_COLLIDE=1 for that cycle. Different indices: both take effect.
//  Doorbell: bus write commit to idx 0 (any lane) sets LOC_IRQ; LOC_IRQ_ACK clears it;
//   simultaneous set and ack -> LOC_IRQ=1. Local write to idx 0 does not set IRQ.
//  LOC_RDATA reflects writes the cycle after commit. Back-to-back cycles: new hit is only
//   accepted from IDLE, so AS_n must be seen high (REL) between cycles.
// TESTING
//  1 Read idx 2 (reg=16'hBEEF), WS=0, A=E90004: DTACK_n=0 1 clk after hit, D_OUT=BEEF, D_OE=1;
//    AS_n high -> REL drives DTACK_n=1 one clk, then OE=0.
//  2 Byte write A=E90006, LDS only, D=16'h1234 onto reg 16'hAAAA -> reg3=16'hAA34.
//  3 WAIT_STATES=3 read: DTACK_n falls exactly 4 clks after hit; AS_n abort in WAIT -> no DTACK.
//  4 A=E90010 (outside window) -> DTACK_OE, D_OE stay 0 for whole cycle.
//  5 Bus write idx0 + LOC_WE idx0 same clk -> reg0=bus data, LOC_COLLIDE=1, LOC_IRQ=1;
//    LOC_IRQ_ACK next clk -> LOC_IRQ=0.
//  6 Reset asserted while in ACK, released with AS_n still 0 -> outputs idle, no new DTACK
//    until AS_n seen high then a fresh hit.

Source files
------------

// File: rtl/m68k_reg_target_if.sv
`default_nettype none
// ============================================================================
// Module      : m68k_reg_target_if
// Description : 68000 bus signal bundle between bus initiator and responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface m68k_reg_target_if;
  logic [23:1] M68K_A;
  logic        M68K_AS_n;
  logic        M68K_UDS_n;
  logic        M68K_LDS_n;
  logic        M68K_RW;
  logic [15:0] M68K_D_IN;
  logic [15:0] M68K_D_OUT;
  logic        M68K_D_OE;
  logic        M68K_DTACK_n;
  logic        M68K_DTACK_OE;

  modport master (
    output M68K_A, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_D_IN,
    input  M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_DTACK_OE
  );

  modport slave (
    input  M68K_A, M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW, M68K_D_IN,
    output M68K_D_OUT, M68K_D_OE, M68K_DTACK_n, M68K_DTACK_OE
  );
endinterface
`default_nettype wire

// File: rtl/m68k_reg_target.sv
`default_nettype none
// ============================================================================
// Module      : m68k_reg_target
// Description : 68000 bus responder for a small word register window with
//               optional wait states, local access port and doorbell IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module m68k_reg_target #(
  parameter logic [23:0] BASE_ADDR   = 24'hE90000,
  parameter int          ADDR_BITS   = 3,
  parameter int          WAIT_STATES = 0
) (
  input  wire                  M68K_CLK,
  input  wire                  M68K_RESET_n,
  m68k_reg_target_if.slave     bus,
  input  wire [ADDR_BITS-1:0]  LOC_ADDR,
  output logic [15:0]          LOC_RDATA,
  input  wire                  LOC_WE,
  input  wire [15:0]           LOC_WDATA,
  output logic                 LOC_IRQ,
  input  wire                  LOC_IRQ_ACK,
  output logic                 LOC_COLLIDE
);

  localparam int         c_nregs  = 1 << ADDR_BITS;
  localparam logic [3:0] c_ws_m1  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t               r_state, w_next;
  logic [3:0]           r_cnt, w_cnt_next;
  logic [ADDR_BITS-1:0] r_idx, w_idx;
  logic                 r_rw, w_rw;
  logic                 r_armed;
  logic [15:0]          r_d_out;
  logic [15:0]          r_regs [c_nregs];
  logic                 r_irq;
  logic                 r_collide;

  logic w_hit, w_enter_ack, w_bus_wr, w_collide, w_loc_wr;

  // A cycle already in progress at reset release is ignored until AS_n is seen high.
  assign w_hit = !bus.M68K_AS_n && r_armed &&
                 (bus.M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);

  assign w_idx = (r_state == S_IDLE) ? bus.M68K_A[ADDR_BITS:1] : r_idx;
  assign w_rw  = (r_state == S_IDLE) ? bus.M68K_RW : r_rw;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          if (WAIT_STATES == 0) begin
            w_next = S_ACK;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = c_ws_m1;
          end
        end
      end
      S_WAIT: begin
        if (bus.M68K_AS_n)      w_next = S_IDLE;
        else if (r_cnt == 4'd0) w_next = S_ACK;
        else                    w_cnt_next = r_cnt - 4'd1;
      end
      S_ACK:   if (bus.M68K_AS_n) w_next = S_REL;
      S_REL:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Writes commit exactly once, on the edge that enters ACK.
  assign w_enter_ack = (w_next == S_ACK) && (r_state != S_ACK);
  assign w_bus_wr    = w_enter_ack && !w_rw && !(bus.M68K_UDS_n && bus.M68K_LDS_n);
  assign w_collide   = w_bus_wr && LOC_WE && (LOC_ADDR == w_idx);
  assign w_loc_wr    = LOC_WE && !w_collide;

  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_rw      <= 1'b1;
      r_armed   <= 1'b0;
      r_d_out   <= 16'h0000;
      r_irq     <= 1'b0;
      r_collide <= 1'b0;
      for (int i = 0; i < c_nregs; i++) r_regs[i] <= 16'h0000;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_next;
      r_collide <= w_collide;
      if (bus.M68K_AS_n) r_armed <= 1'b1;
      if (r_state == S_IDLE && w_hit) begin
        r_idx <= w_idx;
        r_rw  <= w_rw;
      end
      if (w_enter_ack && w_rw) r_d_out <= r_regs[w_idx];
      if (w_loc_wr) r_regs[LOC_ADDR] <= LOC_WDATA;
      if (w_bus_wr) begin
        if (!bus.M68K_UDS_n) r_regs[w_idx][15:8] <= bus.M68K_D_IN[15:8];
        if (!bus.M68K_LDS_n) r_regs[w_idx][7:0]  <= bus.M68K_D_IN[7:0];
      end
      // Doorbell set wins over a simultaneous acknowledge.
      if (w_bus_wr && (w_idx == '0)) r_irq <= 1'b1;
      else if (LOC_IRQ_ACK)          r_irq <= 1'b0;
    end
  end

  assign bus.M68K_DTACK_OE = (r_state == S_ACK) || (r_state == S_REL);
  assign bus.M68K_DTACK_n  = (r_state != S_ACK);
  assign bus.M68K_D_OE     = (r_state == S_ACK) && r_rw;
  assign bus.M68K_D_OUT    = r_d_out;

  assign LOC_RDATA   = r_regs[LOC_ADDR];
  assign LOC_IRQ     = r_irq;
  assign LOC_COLLIDE = r_collide;

endmodule
`default_nettype wire
